// File: rtl/packet_rx_ctrl.sv
// Post-header packet receiver: length capture, payload framing,
// checksum check, idle timeout and saturating error count.
module packet_rx_ctrl #(
   parameter int MAX_LEN = 16,
   parameter int TIMEOUT = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] X,
   input  logic       x_vld,
   input  logic       hdr_det,
   output logic [7:0] out_data,
   output logic       out_vld,
   output logic       out_sof,
   output logic       out_eof,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic [7:0] err_cnt,
   output logic       busy,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LEN     = 2'd1,
      PAYLOAD = 2'd2,
      CSUM    = 2'd3
   } state_t;

   state_t     state_q, state_d;
   logic [7:0] len_q, len_d;
   logic [7:0] cnt_q, cnt_d;
   logic [7:0] csum_q, csum_d;
   logic [7:0] idle_q, idle_d;
   logic [7:0] data_d;
   logic       vld_d, sof_d, eof_d, ok_d, err_d;

   assign state = state_q;

   // State register, packet context and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         len_q    <= '0;
         cnt_q    <= '0;
         csum_q   <= '0;
         idle_q   <= '0;
         out_data <= '0;
         out_vld  <= 1'b0;
         out_sof  <= 1'b0;
         out_eof  <= 1'b0;
         pkt_ok   <= 1'b0;
         pkt_err  <= 1'b0;
         err_cnt  <= '0;
         busy     <= 1'b0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         csum_q   <= csum_d;
         idle_q   <= idle_d;
         out_data <= data_d;
         out_vld  <= vld_d;
         out_sof  <= sof_d;
         out_eof  <= eof_d;
         pkt_ok   <= ok_d;
         pkt_err  <= err_d;
         busy     <= (state_d != IDLE);
         if (err_d && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
      end
   end

   // Next-state, framing and error decisions for the current byte
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      csum_d  = csum_q;
      idle_d  = idle_q;
      data_d  = out_data;
      vld_d   = 1'b0;
      sof_d   = 1'b0;
      eof_d   = 1'b0;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      if (state_q == IDLE) begin
         idle_d = '0;
         if (hdr_det)
            state_d = LEN;
      end else if (!x_vld) begin
         if (idle_q == 8'(TIMEOUT - 1)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            idle_d  = '0;
         end else begin
            idle_d = idle_q + 8'd1;
         end
      end else begin
         idle_d = '0;
         case (state_q)
            LEN: begin
               if (X == 8'd0 || X > 8'(MAX_LEN)) begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end else begin
                  len_d   = X;
                  cnt_d   = '0;
                  csum_d  = '0;
                  state_d = PAYLOAD;
               end
            end
            PAYLOAD: begin
               data_d = X;
               vld_d  = 1'b1;
               sof_d  = (cnt_q == 8'd0);
               eof_d  = (cnt_q == len_q - 8'd1);
               csum_d = csum_q + X;
               cnt_d  = cnt_q + 8'd1;
               if (cnt_q == len_q - 8'd1)
                  state_d = CSUM;
            end
            CSUM: begin
               if (X == csum_q)
                  ok_d = 1'b1;
               else
                  err_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_packet_rx_ctrl.sv
// Directed bench for packet_rx_ctrl: framing, checksum, length,
// timeout, gaps, hdr_det ignore, async reset and err_cnt saturation.
module tb_packet_rx_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] X;
   logic       x_vld;
   logic       hdr_det;
   logic [7:0] out_data;
   logic       out_vld;
   logic       out_sof;
   logic       out_eof;
   logic       pkt_ok;
   logic       pkt_err;
   logic [7:0] err_cnt;
   logic       busy;
   logic [1:0] state;

   int checks;
   int failures;

   // {state, out_vld, out_sof, out_eof, pkt_ok, pkt_err}
   logic [6:0] flags;
   assign flags = {state, out_vld, out_sof, out_eof, pkt_ok, pkt_err};

   packet_rx_ctrl #(.MAX_LEN(16), .TIMEOUT(8)) dut (
      .clk(clk),
      .reset(reset),
      .X(X),
      .x_vld(x_vld),
      .hdr_det(hdr_det),
      .out_data(out_data),
      .out_vld(out_vld),
      .out_sof(out_sof),
      .out_eof(out_eof),
      .pkt_ok(pkt_ok),
      .pkt_err(pkt_err),
      .err_cnt(err_cnt),
      .busy(busy),
      .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Apply one input cycle, then sample #1 after the edge
   task automatic step(input logic [7:0] b, input logic v, input logic h);
      X = b;
      x_vld = v;
      hdr_det = h;
      @(posedge clk);
      #1;
      X = 8'h00;
      x_vld = 1'b0;
      hdr_det = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      X = 8'h00;
      x_vld = 1'b0;
      hdr_det = 1'b0;
      reset = 1'b1;
      #12;
      checks++;
      if (flags !== 7'b00_00000) begin
         failures++;
         $display("FAIL rst_flags got=%b exp=%b", flags, 7'b00_00000);
      end
      checks++;
      if ({out_data, err_cnt, busy} !== 17'd0) begin
         failures++;
         $display("FAIL rst_vals data=%h err_cnt=%h busy=%b exp=0",
                  out_data, err_cnt, busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_nominal();
      step(8'h00, 1'b0, 1'b1);
      checks++;
      if (flags !== 7'b01_00000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL nom_hdr flags=%b busy=%b exp=0100000/1", flags, busy);
      end
      step(8'h03, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_00000) begin
         failures++;
         $display("FAIL nom_len flags=%b exp=1000000", flags);
      end
      step(8'h01, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_11000 || out_data !== 8'h01) begin
         failures++;
         $display("FAIL nom_p0 flags=%b data=%h exp=1011000/01", flags, out_data);
      end
      step(8'h02, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_10000 || out_data !== 8'h02) begin
         failures++;
         $display("FAIL nom_p1 flags=%b data=%h exp=1010000/02", flags, out_data);
      end
      step(8'h03, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b11_10100 || out_data !== 8'h03) begin
         failures++;
         $display("FAIL nom_p2 flags=%b data=%h exp=1110100/03", flags, out_data);
      end
      step(8'h06, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00010 || busy !== 1'b0) begin
         failures++;
         $display("FAIL nom_csum flags=%b busy=%b exp=0000010/0", flags, busy);
      end
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (flags !== 7'b00_00000 || err_cnt !== 8'h00) begin
         failures++;
         $display("FAIL nom_after flags=%b err_cnt=%h exp=0000000/00",
                  flags, err_cnt);
      end
   endtask

   task automatic test_bad_csum();
      do_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'h03, 1'b1, 1'b0);
      step(8'h01, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_11000 || out_data !== 8'h01) begin
         failures++;
         $display("FAIL bad_p0 flags=%b data=%h exp=1011000/01", flags, out_data);
      end
      step(8'h02, 1'b1, 1'b0);
      step(8'h03, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b11_10100 || out_data !== 8'h03) begin
         failures++;
         $display("FAIL bad_p2 flags=%b data=%h exp=1110100/03", flags, out_data);
      end
      step(8'h07, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00001 || err_cnt !== 8'h01) begin
         failures++;
         $display("FAIL bad_csum flags=%b err_cnt=%h exp=0000001/01",
                  flags, err_cnt);
      end
   endtask

   task automatic test_bad_len();
      do_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00001 || err_cnt !== 8'h01) begin
         failures++;
         $display("FAIL len_zero flags=%b err_cnt=%h exp=0000001/01",
                  flags, err_cnt);
      end
      step(8'h00, 1'b0, 1'b1);
      step(8'h11, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00001 || err_cnt !== 8'h02) begin
         failures++;
         $display("FAIL len_big flags=%b err_cnt=%h exp=0000001/02",
                  flags, err_cnt);
      end
      step(8'h00, 1'b0, 1'b1);
      step(8'h10, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_00000) begin
         failures++;
         $display("FAIL len_max flags=%b exp=1000000", flags);
      end
   endtask

   task automatic test_timeout();
      do_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'h04, 1'b1, 1'b0);
      step(8'h10, 1'b1, 1'b0);
      step(8'h20, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++)
         step(8'h00, 1'b0, 1'b0);
      checks++;
      if (flags !== 7'b10_00000 || busy !== 1'b1) begin
         failures++;
         $display("FAIL to_idle7 flags=%b busy=%b exp=1000000/1", flags, busy);
      end
      step(8'h00, 1'b0, 1'b0);
      checks++;
      if (flags !== 7'b00_00001 || busy !== 1'b0 || err_cnt !== 8'h01) begin
         failures++;
         $display("FAIL to_abort flags=%b busy=%b err_cnt=%h exp=0000001/0/01",
                  flags, busy, err_cnt);
      end
      step(8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 7; i++)
         step(8'h00, 1'b0, 1'b0);
      step(8'h02, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_00000) begin
         failures++;
         $display("FAIL gap_len flags=%b exp=1000000", flags);
      end
      for (int i = 0; i < 7; i++)
         step(8'h00, 1'b0, 1'b0);
      step(8'h05, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b10_11000 || out_data !== 8'h05) begin
         failures++;
         $display("FAIL gap_p0 flags=%b data=%h exp=1011000/05", flags, out_data);
      end
      for (int i = 0; i < 7; i++)
         step(8'h00, 1'b0, 1'b0);
      step(8'h09, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b11_10100 || out_data !== 8'h09) begin
         failures++;
         $display("FAIL gap_p1 flags=%b data=%h exp=1110100/09", flags, out_data);
      end
      step(8'h0E, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00010 || err_cnt !== 8'h01) begin
         failures++;
         $display("FAIL gap_csum flags=%b err_cnt=%h exp=0000010/01",
                  flags, err_cnt);
      end
   endtask

   task automatic test_len1_hdr_ignore();
      do_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b0, 1'b0);
      step(8'h01, 1'b1, 1'b0);
      step(8'h00, 1'b0, 1'b1);
      checks++;
      if (flags !== 7'b10_00000) begin
         failures++;
         $display("FAIL l1_hdr_gap flags=%b exp=1000000", flags);
      end
      step(8'hAA, 1'b1, 1'b1);
      checks++;
      if (flags !== 7'b11_11100 || out_data !== 8'hAA) begin
         failures++;
         $display("FAIL l1_pay flags=%b data=%h exp=1111100/aa", flags, out_data);
      end
      step(8'h00, 1'b0, 1'b1);
      checks++;
      if (flags !== 7'b11_00000) begin
         failures++;
         $display("FAIL l1_gap flags=%b exp=1100000", flags);
      end
      step(8'hAA, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00010 || err_cnt !== 8'h00) begin
         failures++;
         $display("FAIL l1_csum flags=%b err_cnt=%h exp=0000010/00",
                  flags, err_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      step(8'h00, 1'b0, 1'b1);
      step(8'h00, 1'b1, 1'b0);
      checks++;
      if (err_cnt !== 8'h01) begin
         failures++;
         $display("FAIL mid_pre err_cnt=%h exp=01", err_cnt);
      end
      step(8'h00, 1'b0, 1'b1);
      step(8'h02, 1'b1, 1'b0);
      step(8'h11, 1'b1, 1'b0);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if (flags !== 7'b00_00000 || out_data !== 8'h00 ||
          err_cnt !== 8'h00 || busy !== 1'b0) begin
         failures++;
         $display("FAIL mid_async flags=%b data=%h err_cnt=%h busy=%b exp=0",
                  flags, out_data, err_cnt, busy);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(8'h22, 1'b1, 1'b0);
      checks++;
      if (flags !== 7'b00_00000 || err_cnt !== 8'h00) begin
         failures++;
         $display("FAIL mid_after flags=%b err_cnt=%h exp=0000000/00",
                  flags, err_cnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int i = 0; i < 300; i++) begin
         step(8'h00, 1'b0, 1'b1);
         step(8'h00, 1'b1, 1'b0);
         if (i == 254) begin
            checks++;
            if (err_cnt !== 8'hFF) begin
               failures++;
               $display("FAIL sat_255 err_cnt=%h exp=ff", err_cnt);
            end
         end
      end
      checks++;
      if (err_cnt !== 8'hFF || flags !== 7'b00_00001) begin
         failures++;
         $display("FAIL sat_300 err_cnt=%h flags=%b exp=ff/0000001",
                  err_cnt, flags);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_nominal();
      test_bad_csum();
      test_bad_len();
      test_timeout();
      test_len1_hdr_ignore();
      test_reset_mid();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
